// File: rtl/camera_pixel_capture.sv
// camera_pixel_capture: samples a parallel camera bus in the system clock domain and emits
// x/y-tagged pixels with frame start/end markers and a sticky malformed-frame flag.
module camera_pixel_capture #(
  parameter int frame_width = 640,
  parameter int frame_height = 480,
  parameter int bytes_per_pixel = 2,
  parameter int coord_width = 12
) (
  input  logic                   input_clock,
  input  logic                   reset,
  input  logic                   capture_enable,
  input  logic                   cam_pclk,
  input  logic                   cam_vsync,
  input  logic                   cam_href,
  input  logic [7:0]             cam_data,
  output logic [15:0]            pixel_data,
  output logic                   pixel_valid,
  output logic [coord_width-1:0] pixel_x,
  output logic [coord_width-1:0] pixel_y,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   frame_error
);
  typedef enum logic {WAIT_VSYNC, ACTIVE} state_t;
  localparam logic [coord_width-1:0] x_max = coord_width'(frame_width);
  localparam logic [coord_width-1:0] x_last = coord_width'(frame_width - 1);
  localparam logic [coord_width-1:0] y_last = coord_width'(frame_height - 1);
  localparam bit two_byte = (bytes_per_pixel == 2);
  // bus bits: [10:3] data, [2] href, [1] vsync, [0] pclk; s3_q is the previous synchronized sample
  logic [10:0] s1_q, s2_q, s3_q;
  logic rise_q, vrise_q, vfall_q, hfall_q, href_q;
  logic [7:0] byte_q, hi_q;
  state_t state_q;
  logic [coord_width-1:0] x_q, y_q, px_q, py_q;
  logic phase_q, first_q, err_q, pv_q, fs_q, fe_q;
  logic [15:0] pd_q;
  always_ff @(posedge input_clock) begin
    if (reset) begin
      {s1_q, s2_q, s3_q} <= '0;
      {rise_q, vrise_q, vfall_q, hfall_q, href_q} <= '0;
      byte_q <= '0;
    end else begin
      s1_q <= {cam_data, cam_href, cam_vsync, cam_pclk};
      s2_q <= s1_q;
      s3_q <= s2_q;
      rise_q <= s2_q[0] & ~s3_q[0];
      vrise_q <= s2_q[1] & ~s3_q[1];
      vfall_q <= ~s2_q[1] & s3_q[1];
      hfall_q <= ~s2_q[2] & s3_q[2];
      href_q <= s2_q[2];
      byte_q <= s2_q[10:3];
    end
  end
  always_ff @(posedge input_clock) begin
    if (reset) begin
      state_q <= WAIT_VSYNC;
      x_q <= '0;
      y_q <= '0;
      phase_q <= 1'b0;
      hi_q <= '0;
      first_q <= 1'b0;
      err_q <= 1'b0;
      pd_q <= '0;
      pv_q <= 1'b0;
      px_q <= '0;
      py_q <= '0;
      fs_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      fs_q <= 1'b0;
      fe_q <= 1'b0;
      if (state_q == WAIT_VSYNC) begin
        if (vfall_q && capture_enable) begin
          state_q <= ACTIVE;
          x_q <= '0;
          y_q <= '0;
          phase_q <= 1'b0;
          first_q <= 1'b1;
          err_q <= 1'b0;
        end
      end else if (vrise_q) begin
        err_q <= 1'b1;
        phase_q <= 1'b0;
        state_q <= WAIT_VSYNC;
      end else if (hfall_q) begin
        if (x_q != x_max || phase_q) err_q <= 1'b1;
        x_q <= '0;
        phase_q <= 1'b0;
        y_q <= y_q + coord_width'(1);
        if (y_q == y_last) state_q <= WAIT_VSYNC;
      end else if (rise_q && href_q) begin
        if (x_q == x_max) begin
          err_q <= 1'b1;
        end else if (!phase_q && two_byte) begin
          hi_q <= byte_q;
          phase_q <= 1'b1;
        end else begin
          pv_q <= 1'b1;
          pd_q <= two_byte ? {hi_q, byte_q} : {8'h00, byte_q};
          px_q <= x_q;
          py_q <= y_q;
          fs_q <= first_q;
          fe_q <= (x_q == x_last) && (y_q == y_last);
          first_q <= 1'b0;
          phase_q <= 1'b0;
          x_q <= x_q + coord_width'(1);
        end
      end
    end
  end
  assign pixel_data = pd_q;
  assign pixel_valid = pv_q;
  assign pixel_x = px_q;
  assign pixel_y = py_q;
  assign frame_start = fs_q;
  assign frame_end = fe_q;
  assign frame_error = err_q;
endmodule

// File: doc/camera_pixel_capture.md
Name: camera_pixel_capture

Overview:
- Consumes the image sensor's parallel bus (pclk, vsync, href, 8-bit data); the sensor's XCLK is produced by the clock divider stage.
- Runs entirely in the system clock domain: synchronizes the sensor signals, detects pclk rising edges, pairs bytes into pixels and tags them with x/y coordinates and frame markers.
- Its output feeds the frame buffer writer.
- input_clock must be at least 4x sensor pclk.

Parameters:
- frame_width, 640, active pixels per line.
- frame_height, 480, active lines per frame.
- bytes_per_pixel, 2, sensor bytes per pixel; 1 or 2 only.
- coord_width, 12, width of the x/y counters; must satisfy 2^coord_width > max(frame_width, frame_height).

Ports:
- input_clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- capture_enable  in  1  level; frames are only accepted while high.
- cam_pclk  in  1  sensor pixel clock, asynchronous, treated as data.
- cam_vsync  in  1  asynchronous; high during vertical blanking.
- cam_href  in  1  asynchronous; high while a line's bytes are valid.
- cam_data  in  8  asynchronous sensor byte.
- pixel_data  out  16  assembled pixel. For 1-byte mode: {8'h00, byte}.
- pixel_valid  out  1  1-cycle strobe.
- pixel_x  out  coord_width  column of pixel_data.
- pixel_y  out  coord_width  row of pixel_data.
- frame_start  out  1  1-cycle strobe, coincides with pixel_valid of pixel (0,0).
- frame_end  out  1  1-cycle strobe, coincides with pixel_valid of the last pixel.
- frame_error  out  1  sticky; set on a malformed frame.

Behaviour:
- Reset:
  - All outputs, synchronizer flops, counters and the byte phase clear to 0.
  - State goes to WAIT_VSYNC.
  - Reset mid-frame discards any partial pixel, with no frame_end.
- Synchronization:
  - cam_pclk, cam_vsync, cam_href and cam_data each pass through 2 flops.
  - pclk_rise = sync_pclk & ~prev_pclk.
  - href and data are taken from the same synchronized stage, so they are sampled together on pclk_rise.
- States:
  - WAIT_VSYNC: wait for a synchronized vsync falling edge.
    - If capture_enable = 1 at that edge, go to ACTIVE with x = 0, y = 0, phase = 0, first = 1.
    - Otherwise stay.
  - ACTIVE, on pclk_rise with href = 1:
    - Store the byte.
    - If phase = 0 and bytes_per_pixel = 2: hold it as the high byte and set phase = 1.
    - Otherwise: emit the pixel on the next input_clock, i.e. pixel_data = {high, low}, pixel_valid = 1, pixel_x = x, pixel_y = y. Then set phase = 0 and x = x + 1.
  - ACTIVE, on a synchronized href falling edge (end of line):
    - If x != frame_width, or phase != 0, set frame_error.
    - Then set x = 0, phase = 0, y = y + 1.
    - If the line just closed was y = frame_height - 1, go to WAIT_VSYNC.
  - ACTIVE, on a synchronized vsync rising edge before frame_height lines are complete: set frame_error and go to WAIT_VSYNC. Any partial pixel is dropped.
- Line overflow:
  - Bytes beyond frame_width pixels in a line are not emitted.
  - frame_error is set.
  - x saturates at frame_width.
- Frame markers:
  - frame_start accompanies the first pixel_valid after entering ACTIVE.
  - frame_end accompanies the pixel with x = frame_width - 1 and y = frame_height - 1.
- capture_enable:
  - Deasserting during ACTIVE does not abort; the current frame completes.
  - Sampled only at the vsync falling edge.
- frame_error clears only on reset, or at entry to ACTIVE when capture_enable = 1.
- Latency: pixel_valid asserts exactly 4 input_clock cycles after the cam_pclk rising edge carrying the final byte of the pixel (2 sync + 1 edge detect + 1 output register).
- pixel_data, pixel_x and pixel_y hold their last value when pixel_valid = 0.

Test Plan:
- Reset then idle: reset held 3 cycles, sensor static. Required: all outputs 0, no pixel_valid.
- Small full frame: frame_width = 4, frame_height = 2, bytes_per_pixel = 2, pclk = input_clock/4, bytes 8'h10 to 8'h1F. Required:
  - 8 pixel_valid strobes with pixel_data 16'h1011, 16'h1213, ... 16'h1E1F.
  - (x, y) runs (0,0) to (3,1).
  - frame_start on the first strobe, frame_end on the last, frame_error = 0.
  - Each strobe exactly 4 cycles after the second byte's pclk edge.
- Enable gating: capture_enable = 0 at the vsync fall, raised mid-frame. Required: no output for that frame; the next frame is captured normally.
- Short line: line 0 carries 3 pixels with frame_width = 4. Required: 3 pixels emitted, frame_error = 1, line 1 starts at x = 0, y = 1.
- Early vsync: vsync rises after 1 of 2 lines. Required: frame_error = 1, no frame_end. The next clean frame clears frame_error and yields 8 pixels.
- Reset mid-pixel: reset asserted after a high byte. Required: no pixel_valid. The following frame's first pixel is its own byte pair, with no stale high byte.
